pkt_hdr_extractor: RTL and testbench

PKT_HDR_EXTRACTOR -- requirements
Module: pkt_hdr_extractor

---
 rtl/pkt_hdr_extractor.sv | 157 +++++++++++++++
 tb/tb_pkt_hdr_extractor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_hdr_extractor.sv
// Taps an AXI-Stream and captures the first HDR_BEATS beats of each packet
// into a header vector with a byte count, handed off over valid/ready.
module pkt_hdr_extractor #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int HDR_BEATS           = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                                     s_axis_tvalid,
    input  logic                                     s_axis_tready,
    input  logic                                     s_axis_tlast,
    output logic                                     m_phv_valid,
    input  logic                                     m_phv_ready,
    output logic [C_S_AXIS_DATA_WIDTH*HDR_BEATS-1:0] m_phv_hdr,
    output logic [7:0]                               m_phv_len,
    output logic [15:0]                              drop_cnt
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int HW = DW * HDR_BEATS;
    localparam int IW = $clog2(HDR_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SKIP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   beat_idx;
    logic [HW-1:0]   cap_buf;
    logic [7:0]      len_acc;
    logic            cap_done;

    logic            beat;
    logic            last_slot;
    logic            first;
    logic            store;
    logic            complete;
    logic            out_free;
    logic [DW-1:0]   beat_data;
    logic [7:0]      beat_bytes;

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign last_slot = (beat_idx == IW'(HDR_BEATS - 1));
    assign out_free  = !m_phv_valid || m_phv_ready;

    always_comb begin
        beat_data  = '0;
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_data[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
            beat_bytes          = beat_bytes + 8'(s_axis_tkeep[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (beat && !s_axis_tlast) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (beat && s_axis_tlast) begin
                    state_nxt = IDLE;
                end else if (beat && last_slot) begin
                    state_nxt = SKIP;
                end
            end
            SKIP: begin
                if (beat && s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        first    = 1'b0;
        store    = 1'b0;
        complete = 1'b0;
        unique case (state)
            IDLE: begin
                first    = beat;
                complete = beat && s_axis_tlast;
            end
            CAPTURE: begin
                store    = beat;
                complete = beat && (s_axis_tlast || last_slot);
            end
            default: begin
                first    = 1'b0;
            end
        endcase
    end

    // The capture buffer doubles as the staging register: the output loads
    // from it one edge after completion, the same edge a new packet may overwrite it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_idx <= '0;
            len_acc  <= '0;
            cap_buf  <= '0;
            cap_done <= 1'b0;
        end else begin
            cap_done <= complete;
            if (first) begin
                cap_buf  <= {{(HW - DW){1'b0}}, beat_data};
                len_acc  <= beat_bytes;
                beat_idx <= s_axis_tlast ? '0 : IW'(1);
            end else if (store) begin
                for (int k = 0; k < HDR_BEATS; k++) begin
                    if (beat_idx == IW'(k)) begin
                        cap_buf[k*DW +: DW] <= beat_data;
                    end
                end
                len_acc  <= len_acc + beat_bytes;
                beat_idx <= complete ? '0 : beat_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phv_valid <= 1'b0;
            m_phv_hdr   <= '0;
            m_phv_len   <= '0;
            drop_cnt    <= '0;
        end else if (cap_done) begin
            if (out_free) begin
                m_phv_valid <= 1'b1;
                m_phv_hdr   <= cap_buf;
                m_phv_len   <= len_acc;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (m_phv_valid && m_phv_ready) begin
            m_phv_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_hdr_extractor.sv
// Randomized bench for pkt_hdr_extractor: packet-level reference vectors,
// an occupancy/drop model and a monitor that checks every accepted vector.
module tb_pkt_hdr_extractor;

    localparam int DW = 256;
    localparam int NB = 4;
    localparam int HW = DW * NB;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [7:0]    len;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [31:0]   s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          m_phv_valid;
    logic          m_phv_ready = 1'b1;
    logic [HW-1:0] m_phv_hdr;
    logic [7:0]    m_phv_len;
    logic [15:0]   drop_cnt;

    logic          cmpl_tag = 1'b0;
    int            rdy_mode = 0;
    int            checks = 0;
    int            failures = 0;

    vec_t          pkt_q[$];
    vec_t          exp_q[$];
    bit            occ = 1'b0;
    bit            pend = 1'b0;
    vec_t          pend_v;
    int            drops = 0;

    pkt_hdr_extractor #(
        .C_S_AXIS_DATA_WIDTH(DW),
        .HDR_BEATS(NB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_phv_valid(m_phv_valid),
        .m_phv_ready(m_phv_ready),
        .m_phv_hdr(m_phv_hdr),
        .m_phv_len(m_phv_len),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_hdr(input string nm, input logic [HW-1:0] exp);
        int fk;
        checks++;
        if (m_phv_hdr !== exp) begin
            failures++;
            fk = 0;
            for (int k = NB - 1; k >= 0; k--) begin
                if (m_phv_hdr[k*DW +: DW] !== exp[k*DW +: DW]) fk = k;
            end
            $display("FAIL %s beat %0d: got %h expected %h", nm, fk,
                     m_phv_hdr[fk*DW +: DW], exp[fk*DW +: DW]);
        end
    endtask

    // Reference: a completed vector loads one edge later if the output is free,
    // otherwise it is dropped; a held vector leaves on valid&ready.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                occ   = 1'b0;
                pend  = 1'b0;
                drops = 0;
                exp_q.delete();
            end else begin
                if (pend) begin
                    if (!occ || m_phv_ready) begin
                        exp_q.push_back(pend_v);
                        occ = 1'b1;
                    end else if (drops != 65535) begin
                        drops++;
                    end
                    pend = 1'b0;
                end else if (occ && m_phv_ready) begin
                    occ = 1'b0;
                end
                if (s_axis_tvalid && s_axis_tready && cmpl_tag) begin
                    if (pkt_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL model: completion with no reference packet");
                    end else begin
                        pend_v = pkt_q.pop_front();
                        pend   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        bit            held;
        logic [HW-1:0] h_hdr;
        logic [7:0]    h_len;
        vec_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_valid", 32'(m_phv_valid), 32'd0);
                chk("rst_len", 32'(m_phv_len), 32'd0);
                chk("rst_drop", 32'(drop_cnt), 32'd0);
                chk("rst_hdr_nonzero", 32'(m_phv_hdr != '0), 32'd0);
                held = 1'b0;
            end else begin
                chk("valid", 32'(m_phv_valid), 32'(occ));
                chk("drop_cnt", 32'(drop_cnt), 32'(drops));
                if (held) begin
                    chk("hold_len", 32'(m_phv_len), 32'(h_len));
                    chk("hold_hdr_changed", 32'(m_phv_hdr != h_hdr), 32'd0);
                end
                if (m_phv_valid && m_phv_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL accept: unexpected vector len=%0d", m_phv_len);
                    end else begin
                        e = exp_q.pop_front();
                        chk("len", 32'(m_phv_len), 32'(e.len));
                        chk_hdr("hdr", e.hdr);
                    end
                end
                held  = m_phv_valid && !m_phv_ready;
                h_hdr = m_phv_hdr;
                h_len = m_phv_len;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_phv_ready = 1'b1;
                1:       m_phv_ready = 1'b0;
                default: m_phv_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tready = s_axis_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
            s_axis_tlast  = 1'($urandom_range(0, 1));
            s_axis_tkeep  = $urandom;
            for (int j = 0; j < 8; j++) s_axis_tdata[j*32 +: 32] = $urandom;
            cmpl_tag      = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [31:0] k,
                             input logic l, input logic tag, input int gaps);
        idle(gaps);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        cmpl_tag      = tag;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        cmpl_tag      = 1'b0;
    endtask

    // kmode: 0 all keeps full, 1 random keeps, 2 full except last beat = klast
    task automatic send_pkt(input int n, input int gmax, input int kmode,
                            input logic [31:0] klast);
        logic [DW-1:0] d[8];
        logic [31:0]   k[8];
        vec_t          v;
        int            nc;
        nc = (n < NB) ? n : NB;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) d[i][j*32 +: 32] = $urandom;
            k[i] = (kmode == 1) ? $urandom : 32'hFFFF_FFFF;
            if (kmode == 2 && i == n - 1) k[i] = klast;
        end
        v.hdr = '0;
        v.len = '0;
        for (int i = 0; i < nc; i++) begin
            for (int b = 0; b < 32; b++) begin
                if (k[i][b]) begin
                    v.hdr[i*DW + b*8 +: 8] = d[i][b*8 +: 8];
                    v.len = v.len + 8'd1;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i == nc - 1) pkt_q.push_back(v);
            send_beat(d[i], k[i], 1'(i == n - 1), 1'(i == nc - 1),
                      (gmax == 0) ? 0 : $urandom_range(0, gmax));
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        send_pkt(1, 0, 2, 32'h0000_FFFF);
        idle(3);
        send_pkt(6, 1, 0, 32'h0);
        send_pkt(2, 0, 1, 32'h0);
        idle(3);
        send_pkt(4, 0, 2, 32'h0000_00FF);
        send_pkt(1, 0, 1, 32'h0);
        idle(3);

        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tready = 1'b0;
            s_axis_tlast  = 1'b1;
            s_axis_tkeep  = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
        end
        send_pkt(1, 0, 2, 32'h0000_000F);
        idle(3);

        rdy_mode = 1;
        idle(2);
        send_pkt(1, 0, 1, 32'h0);
        send_pkt(1, 2, 1, 32'h0);
        idle(4);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        rdy_mode = 0;
        idle(4);

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
            send_beat(rd, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        end
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        send_pkt(3, 1, 1, 32'h0);
        idle(3);

        rdy_mode = 2;
        for (int p = 0; p < 60; p++) begin
            send_pkt($urandom_range(1, 7), (p % 3 == 0) ? 0 : 3,
                     $urandom_range(0, 1), 32'h0);
        end
        rdy_mode = 0;
        idle(12);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("pkt_q_empty", 32'(pkt_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
